// File: rtl/fan_ctrl_pkg.sv
// Shared constants and the channel mode encoding for the fan PWM divider.
package fan_ctrl_pkg;

    localparam int unsigned WIDTH_DEF      = 32;
    localparam int unsigned PERIOD_RST_DEF = 255;

    typedef enum logic {
        MODE_PWM    = 1'b0,
        MODE_TOGGLE = 1'b1
    } fan_mode_e;

endpackage : fan_ctrl_pkg

// File: rtl/fan_pwm_divider_if.sv
// Settings/status bundle between a fan-control master and the divider.
interface fan_pwm_divider_if
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned WIDTH  = WIDTH_DEF
);

    logic [WIDTH-1:0]        prescale_in;
    logic [NUM_CH-1:0]       enable_in;
    logic [NUM_CH-1:0]       mode_in;
    logic [NUM_CH*WIDTH-1:0] period_in;
    logic [NUM_CH*WIDTH-1:0] duty_in;
    logic [NUM_CH-1:0]       load_in;
    logic [NUM_CH-1:0]       busy_out;
    logic [NUM_CH-1:0]       wrap_out;
    logic [NUM_CH-1:0]       pwm_out;

    modport master (
        output prescale_in, enable_in, mode_in, period_in, duty_in, load_in,
        input  busy_out, wrap_out, pwm_out
    );

    modport slave (
        input  prescale_in, enable_in, mode_in, period_in, duty_in, load_in,
        output busy_out, wrap_out, pwm_out
    );

endinterface : fan_pwm_divider_if

// File: rtl/fan_pwm_divider_channel.sv
// One divider channel: double-buffered period/duty, tick-driven counter,
// PWM or toggled output. New settings only land on a period boundary.
module fan_pwm_channel
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH      = WIDTH_DEF,
    parameter logic [WIDTH-1:0] PERIOD_RST = WIDTH'(PERIOD_RST_DEF)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             enable_i,
    input  fan_mode_e        mode_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0] duty_i,
    input  logic             load_i,
    output logic             busy_o,
    output logic             wrap_o,
    output logic             pwm_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] perAct_q, perAct_d;
    logic [WIDTH-1:0] dutyAct_q, dutyAct_d;
    logic [WIDTH-1:0] perPend_q, perPend_d;
    logic [WIDTH-1:0] dutyPend_q, dutyPend_d;
    logic             busy_q, busy_d;
    logic             wrap_q, wrap_d;
    logic             pwm_q, pwm_d;
    logic             atEnd;
    logic             applyNow;

    always_comb begin
        cnt_d      = cnt_q;
        perAct_d   = perAct_q;
        dutyAct_d  = dutyAct_q;
        perPend_d  = perPend_q;
        dutyPend_d = dutyPend_q;
        busy_d     = busy_q;
        wrap_d     = 1'b0;
        pwm_d      = pwm_q;

        // The >= compare keeps cnt+1 from ever overflowing, even at period = all ones.
        atEnd    = tick_i && (cnt_q >= perAct_q);
        applyNow = busy_q && (!enable_i || atEnd);

        if (applyNow) begin
            perAct_d  = perPend_q;
            dutyAct_d = dutyPend_q;
            busy_d    = 1'b0;
        end

        // A fresh load overrides a same-cycle apply: it becomes the next pending value.
        if (load_i) begin
            perPend_d  = period_i;
            dutyPend_d = duty_i;
            busy_d     = 1'b1;
        end

        if (!enable_i) begin
            cnt_d = '0;
            pwm_d = 1'b0;
        end else begin
            if (atEnd) begin
                cnt_d  = '0;
                wrap_d = 1'b1;
            end else if (tick_i) begin
                cnt_d = cnt_q + WIDTH'(1);
            end

            if (mode_i == MODE_TOGGLE) begin
                pwm_d = pwm_q ^ atEnd;
            end else begin
                pwm_d = (cnt_q < dutyAct_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            perAct_q   <= PERIOD_RST;
            dutyAct_q  <= '0;
            perPend_q  <= '0;
            dutyPend_q <= '0;
            busy_q     <= 1'b0;
            wrap_q     <= 1'b0;
            pwm_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            perAct_q   <= perAct_d;
            dutyAct_q  <= dutyAct_d;
            perPend_q  <= perPend_d;
            dutyPend_q <= dutyPend_d;
            busy_q     <= busy_d;
            wrap_q     <= wrap_d;
            pwm_q      <= pwm_d;
        end
    end

    assign busy_o = busy_q;
    assign wrap_o = wrap_q;
    assign pwm_o  = pwm_q;

endmodule : fan_pwm_channel

// File: rtl/fan_pwm_divider.sv
// Fan-control divider top: one free-running shared prescaler feeding NUM_CH
// independent PWM/toggle channels.
module fan_pwm_divider
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned      NUM_CH     = 2,
    parameter int unsigned      WIDTH      = WIDTH_DEF,
    parameter logic [WIDTH-1:0] PERIOD_RST = WIDTH'(PERIOD_RST_DEF)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    fan_pwm_divider_if.slave bus
);

    logic [WIDTH-1:0]  preCnt_q, preCnt_d;
    logic              tick;
    logic [NUM_CH-1:0] busyVec;
    logic [NUM_CH-1:0] wrapVec;
    logic [NUM_CH-1:0] pwmVec;

    // Shrinking prescale_in below the live count still wraps on the next clock.
    always_comb begin
        tick     = (preCnt_q >= bus.prescale_in);
        preCnt_d = tick ? '0 : preCnt_q + WIDTH'(1);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            preCnt_q <= '0;
        end else begin
            preCnt_q <= preCnt_d;
        end
    end

    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        fan_pwm_channel #(
            .WIDTH      (WIDTH),
            .PERIOD_RST (PERIOD_RST)
        ) u_channel (
            .clk_i    (clk_in),
            .rst_ni   (rst_n_in),
            .tick_i   (tick),
            .enable_i (bus.enable_in[c]),
            .mode_i   (fan_mode_e'(bus.mode_in[c])),
            .period_i (bus.period_in[c*WIDTH +: WIDTH]),
            .duty_i   (bus.duty_in[c*WIDTH +: WIDTH]),
            .load_i   (bus.load_in[c]),
            .busy_o   (busyVec[c]),
            .wrap_o   (wrapVec[c]),
            .pwm_o    (pwmVec[c])
        );
    end

    assign bus.busy_out = busyVec;
    assign bus.wrap_out = wrapVec;
    assign bus.pwm_out  = pwmVec;

endmodule : fan_pwm_divider
